digit_serial_magnitude_controller: RTL and testbench

//  Sequences a 2-bit greater-than comparator over WIDTH-bit operands, one
//  2-bit digit per clock, MSB digit first, stopping at the first unequal digit.

---
 rtl/digit_serial_magnitude_controller_pkg.sv | 13 +
 rtl/comparator_digit_gt2.sv | 12 +
 rtl/digit_serial_magnitude_controller.sv | 117 +++++++++++
 tb/tb_digit_serial_magnitude_controller.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/digit_serial_magnitude_controller_pkg.sv
// Shared types and constants for the digit-serial magnitude comparator.
package digit_serial_magnitude_controller_pkg;

  localparam int unsigned DIGIT_W = 2;

  // Encoding 2'd3 is unused; the FSM recovers from it to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/comparator_digit_gt2.sv
// Combinational greater-than on one 2-bit digit.
module comparator_digit_gt2
  import digit_serial_magnitude_controller_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  output logic               gt_o
);

  assign gt_o = (a_i[1] & ~b_i[1]) | (~(a_i[1] ^ b_i[1]) & a_i[0] & ~b_i[0]);

endmodule

// File: rtl/digit_serial_magnitude_controller.sv
// Compares two WIDTH-bit operands one 2-bit digit per clock, MSB digit first,
// stopping at the first unequal digit.
module digit_serial_magnitude_controller
  import digit_serial_magnitude_controller_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                              Clock,
  input  logic                              Reset_b,
  input  logic                              Start,
  input  logic [WIDTH-1:0]                  A,
  input  logic [WIDTH-1:0]                  B,
  output logic                              Busy,
  output logic                              Done,
  output logic                              A_greater_than_B,
  output logic                              A_equal_B,
  output logic [$clog2(WIDTH/2):0]          Digits
);

  localparam int unsigned NDIG = WIDTH / 2;
  localparam int unsigned CW   = $clog2(NDIG) + 1;
  localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_e                          state_q, state_d;
  logic [NDIG-1:0][DIGIT_W-1:0]    a_q, a_d, b_q, b_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic                            gt_q, gt_d, eq_q, eq_d;
  logic                            busy_q, busy_d, done_q, done_d;
  logic [CW-1:0]                   dig_q, dig_d;
  logic [DIGIT_W-1:0]              a_dig, b_dig;
  logic                            dig_gt, dig_eq;

  // Single shared digit comparator fed by the current-digit mux.
  assign a_dig  = a_q[idx_q];
  assign b_dig  = b_q[idx_q];
  assign dig_eq = (a_dig == b_dig);

  comparator_digit_gt2 u_gt2 (
    .a_i  (a_dig),
    .b_i  (b_dig),
    .gt_o (dig_gt)
  );

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dig_q   <= dig_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    dig_d   = dig_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE accepts a new Start exactly like IDLE for back-to-back runs.
        if (Start) begin
          a_d     = A;
          b_d     = B;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          dig_d   = '0;
          idx_d   = IW'(NDIG - 1);
          state_d = ST_COMPARE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMPARE: begin
        dig_d = dig_q + CW'(1);
        if (dig_gt) begin
          gt_d    = 1'b1;
          state_d = ST_DONE;
        end else if (!dig_eq) begin
          state_d = ST_DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_COMPARE);
    done_d = (state_d == ST_DONE);
  end

  assign Busy             = busy_q;
  assign Done             = done_q;
  assign A_greater_than_B = gt_q;
  assign A_equal_B        = eq_q;
  assign Digits           = dig_q;

endmodule

// File: tb/tb_digit_serial_magnitude_controller.sv
// Scoreboard bench: stimulus queues expected results, a monitor checks on Done.
module tb_digit_serial_magnitude_controller;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = $clog2(WIDTH / 2) + 1;

  logic             Clock = 1'b0;
  logic             Reset_b;
  logic             Start;
  logic [WIDTH-1:0] A, B;
  logic             Busy, Done, A_greater_than_B, A_equal_B;
  logic [CW-1:0]    Digits;

  typedef struct {
    logic        gt;
    logic        eq;
    int unsigned dig;
    int unsigned acc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  digit_serial_magnitude_controller #(.WIDTH(WIDTH)) dut (
    .Clock            (Clock),
    .Reset_b          (Reset_b),
    .Start            (Start),
    .A                (A),
    .B                (B),
    .Busy             (Busy),
    .Done             (Done),
    .A_greater_than_B (A_greater_than_B),
    .A_equal_B        (A_equal_B),
    .Digits           (Digits)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void expect_run(logic gt, logic eq, int unsigned dig, int unsigned acc, string nm);
    exp_t e;
    e.gt = gt; e.eq = eq; e.dig = dig; e.acc = acc; e.name = nm;
    sb.push_back(e);
  endfunction

  // Monitor: every Done pulse must match the oldest pending expectation.
  always @(negedge Clock) begin
    if (Reset_b === 1'b1 && Done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got Done=1 expected no pending run");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_gt"},      32'(A_greater_than_B), 32'(e.gt));
        check({e.name, "_eq"},      32'(A_equal_B),        32'(e.eq));
        check({e.name, "_digits"},  32'(Digits),           e.dig);
        check({e.name, "_latency"}, cyc - e.acc,           e.dig);
        check({e.name, "_busy"},    32'(Busy),             32'd0);
      end
    end
  end

  // Called at a negedge; the following posedge is the accepting edge.
  task automatic start_run(logic [7:0] a, logic [7:0] b, logic gt, logic eq,
                           int unsigned dig, string nm, bit push);
    A = a; B = b; Start = 1'b1;
    if (push) expect_run(gt, eq, dig, cyc + 1, nm);
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while ((sb.size() != 0 || Busy || Done) && n < 40) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got still busy after %0d cycles expected idle", nm, n);
    end
  endtask

  task automatic check_all_zero(string nm);
    check({nm, "_busy"},   32'(Busy),             32'd0);
    check({nm, "_done"},   32'(Done),             32'd0);
    check({nm, "_gt"},     32'(A_greater_than_B), 32'd0);
    check({nm, "_eq"},     32'(A_equal_B),        32'd0);
    check({nm, "_digits"}, 32'(Digits),           32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_b = 1'b0; Start = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge Clock);
    check_all_zero("reset");
    Reset_b = 1'b1;
    @(negedge Clock);

    // Early exit on the top digit, then results must hold in IDLE.
    start_run(8'hC4, 8'h3F, 1'b1, 1'b0, 1, "t1_gt_early", 1'b1);
    wait_idle("t1");
    repeat (2) @(negedge Clock);
    check("t1_hold_gt",     32'(A_greater_than_B), 32'd1);
    check("t1_hold_digits", 32'(Digits),           32'd1);

    start_run(8'h5A, 8'h5A, 1'b0, 1'b1, 4, "t2_equal", 1'b1);
    wait_idle("t2");

    start_run(8'h12, 8'h13, 1'b0, 1'b0, 4, "t3_lt_last", 1'b1);
    wait_idle("t3");

    // Start while Busy must be ignored.
    start_run(8'h40, 8'h41, 1'b0, 1'b0, 4, "t4_busy_start", 1'b1);
    check("t4_busy", 32'(Busy), 32'd1);
    A = 8'hFF; B = 8'h00; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    wait_idle("t4");

    // Reset mid-compare aborts with no Done.
    start_run(8'h00, 8'h00, 1'b0, 1'b0, 4, "t5_abort", 1'b0);
    @(negedge Clock);
    check("t5_pre_digits", 32'(Digits), 32'd1);
    Reset_b = 1'b0;
    #1;
    check_all_zero("t5_reset");
    repeat (2) @(negedge Clock);
    Reset_b = 1'b1;
    repeat (6) @(negedge Clock);
    check("t5_no_done", 32'(Done), 32'd0);
    start_run(8'h80, 8'h7F, 1'b1, 1'b0, 1, "t5_after", 1'b1);
    wait_idle("t5");

    // Back-to-back: Start held through Done, operands change mid-compare.
    A = 8'h20; B = 8'h10; Start = 1'b1;
    expect_run(1'b1, 1'b0, 2, cyc + 1, "t6_first");
    @(negedge Clock);
    A = 8'h01; B = 8'h02;
    begin
      int n = 0;
      while (Done !== 1'b1 && n < 20) begin
        @(negedge Clock);
        n++;
      end
      if (n >= 20) begin
        n_cmp++;
        n_bad++;
        $display("FAIL t6_timeout: got no Done after %0d cycles expected Done", n);
      end
    end
    check("t6_busy_in_done", 32'(Busy), 32'd0);
    expect_run(1'b0, 1'b0, 4, cyc + 1, "t6_second");
    @(negedge Clock);
    check("t6_busy_restart", 32'(Busy), 32'd1);
    Start = 1'b0;
    wait_idle("t6");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
